matrix_operand_loader: RTL and testbench

MATRIX_OPERAND_LOADER -- requirements
Module: matrix_operand_loader

---
 rtl/matrix_operand_loader.sv | 120 ++++++++++++
 tb/tb_matrix_operand_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_operand_loader.sv
// Collects a 32-beat frame (16 A elements then 16 B elements, row-major) into two
// 4x4 operand matrices and presents them to the multiplier with a valid/ready hold.
module matrix_operand_loader #(
    parameter int w = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [w-1:0]           in_data,
    input  logic                          in_valid,
    input  logic                          in_sof,
    output logic                          in_ready,
    output logic signed [0:3][0:3][w-1:0] A,
    output logic signed [0:3][0:3][w-1:0] B,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          frame_err
);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        HOLD
    } state_t;

    state_t                    state_q;
    logic [3:0]                idx_q;
    logic [0:3][0:3][w-1:0]    a_q;
    logic [0:3][0:3][w-1:0]    b_q;
    logic                      out_valid_q;
    logic                      frame_err_q;
    logic [1:0]                rst_sync_q;
    logic                      rst_core_n;
    logic                      accept;

    // Assertion is immediate; release reaches the core two edges later, so no
    // beat can be taken in the cycle rst_n is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_core_n = rst_sync_q[1];

    assign in_ready = (state_q != HOLD);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q     <= LOAD_A;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                LOAD_A: begin
                    if (accept) begin
                        if (idx_q == 4'd0 && !in_sof) begin
                            frame_err_q <= 1'b1;
                        end else if (idx_q != 4'd0 && in_sof) begin
                            frame_err_q <= 1'b1;
                            a_q[0][0]   <= in_data;
                            idx_q       <= 4'd1;
                        end else begin
                            a_q[idx_q[3:2]][idx_q[1:0]] <= in_data;
                            if (idx_q == 4'd15) begin
                                state_q <= LOAD_B;
                                idx_q   <= '0;
                            end else begin
                                idx_q <= idx_q + 4'd1;
                            end
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        // A start-of-frame mid-B abandons the partial frame and restarts A.
                        if (in_sof) begin
                            frame_err_q <= 1'b1;
                            a_q[0][0]   <= in_data;
                            idx_q       <= 4'd1;
                            state_q     <= LOAD_A;
                        end else begin
                            b_q[idx_q[3:2]][idx_q[1:0]] <= in_data;
                            if (idx_q == 4'd15) begin
                                state_q     <= HOLD;
                                idx_q       <= '0;
                                out_valid_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 4'd1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= LOAD_A;
                    end
                end
                default: begin
                    state_q     <= LOAD_A;
                    idx_q       <= '0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: framing, hold/backpressure, resync,
// mid-frame reset, extreme values and back-to-back frame spacing.
module tb_matrix_operand_loader;

    localparam int W = 32;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic signed [W-1:0]           in_data;
    logic                          in_valid;
    logic                          in_sof;
    logic                          in_ready;
    logic signed [0:3][0:3][W-1:0] A;
    logic signed [0:3][0:3][W-1:0] B;
    logic                          out_valid;
    logic                          out_ready;
    logic                          frame_err;

    int vectors    = 0;
    int miscompares = 0;

    logic [W-1:0]           fr [32];
    logic [0:3][0:3][W-1:0] exp_A;
    logic [0:3][0:3][W-1:0] exp_B;

    matrix_operand_loader #(.w(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [W-1:0] d, input logic sof);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        cyc();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send(input int lo, input int hi, input bit gaps);
        for (int k = lo; k <= hi; k++) begin
            beat(fr[k], k == 0);
            if (gaps && k != hi) cyc();
        end
    endtask

    task automatic set_frame_seq();
        for (int k = 0; k < 32; k++)
            fr[k] = (k < 16) ? W'(k + 1) : W'(-(k - 15));
    endtask

    task automatic update_expect();
        for (int k = 0; k < 16; k++) begin
            exp_A[k / 4][k % 4] = fr[k];
            exp_B[k / 4][k % 4] = fr[k + 16];
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        vectors++;
        if (A !== '0 || B !== '0) begin miscompares++; $display("FAIL reset_AB: got A=%h B=%h expected all zero", A, B); end
        // A beat offered in the release cycle must be ignored.
        rst_n = 1'b1;
        beat(32'h0000_0BAD, 1'b1);
        cyc();
        cyc();
        vectors++;
        if (A !== '0 || frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_release_beat: got A00=%h err=%b expected 0/0", A[0][0], frame_err); end
    endtask

    task automatic test_basic();
        set_frame_seq();
        update_expect();
        send(0, 30, 1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
        beat(fr[31], 1'b0);
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready_hold: got %b expected 0", in_ready); end
        vectors++;
        if (A[1][2] !== 32'd7) begin miscompares++; $display("FAIL basic_A12: got %h expected 00000007", A[1][2]); end
        vectors++;
        if (B[3][3] !== 32'hFFFF_FFF0) begin miscompares++; $display("FAIL basic_B33: got %h expected fffffff0", B[3][3]); end
        vectors++;
        if (A !== exp_A || B !== exp_B) begin miscompares++; $display("FAIL basic_AB: got A=%h B=%h expected A=%h B=%h", A, B, exp_A, exp_B); end
        handshake();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_drop: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_stall();
        set_frame_seq();
        update_expect();
        send(0, 31, 1'b1);
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (out_valid !== 1'b1 || A !== exp_A || B !== exp_B) begin
                miscompares++;
                $display("FAIL stall_hold cycle %0d: got valid=%b A=%h B=%h expected valid=1 A=%h B=%h", c, out_valid, A, B, exp_A, exp_B);
            end
            cyc();
        end
        handshake();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_missing_sof();
        for (int k = 0; k < 32; k++) fr[k] = 32'h0000_1000 + W'(k);
        update_expect();
        beat(32'h0000_0055, 1'b0);
        vectors++;
        if (frame_err !== 1'b1) begin miscompares++; $display("FAIL nosof_err: got %b expected 1", frame_err); end
        vectors++;
        if (A[0][0] !== 32'd1) begin miscompares++; $display("FAIL nosof_A00: got %h expected 00000001", A[0][0]); end
        beat(fr[0], 1'b1);
        vectors++;
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL nosof_err_width: got %b expected 0", frame_err); end
        send(1, 30, 1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL nosof_early_valid: got %b expected 0", out_valid); end
        beat(fr[31], 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || A !== exp_A || B !== exp_B) begin miscompares++; $display("FAIL nosof_frame: got valid=%b A=%h B=%h expected valid=1 A=%h B=%h", out_valid, A, B, exp_A, exp_B); end
        handshake();
    endtask

    task automatic test_resync();
        set_frame_seq();
        send(0, 19, 1'b0);
        beat(32'd99, 1'b1);
        vectors++;
        if (frame_err !== 1'b1) begin miscompares++; $display("FAIL resync_err: got %b expected 1", frame_err); end
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL resync_state: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
        fr[0] = 32'd99;
        update_expect();
        send(1, 30, 1'b0);
        vectors++;
        if (out_valid !== 1'b0 || frame_err !== 1'b0) begin miscompares++; $display("FAIL resync_early: got valid=%b err=%b expected 0/0", out_valid, frame_err); end
        beat(fr[31], 1'b0);
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL resync_valid: got %b expected 1", out_valid); end
        vectors++;
        if (A[0][0] !== 32'd99 || A !== exp_A || B !== exp_B) begin miscompares++; $display("FAIL resync_AB: got A=%h B=%h expected A=%h B=%h", A, B, exp_A, exp_B); end
        handshake();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 32; k++) fr[k] = 32'h0000_A000 + W'(k);
        send(0, 9, 1'b0);
        rst_n = 1'b0;
        cyc();
        cyc();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_ctrl: got valid=%b ready=%b err=%b expected 0/1/0", out_valid, in_ready, frame_err); end
        vectors++;
        if (A !== '0 || B !== '0) begin miscompares++; $display("FAIL rstmid_AB: got A=%h B=%h expected all zero", A, B); end
        rst_n = 1'b1;
        cyc();
        cyc();
        cyc();
        for (int k = 0; k < 32; k++) fr[k] = 32'h0000_B000 + W'(k);
        update_expect();
        send(0, 31, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || A !== exp_A || B !== exp_B) begin miscompares++; $display("FAIL rstmid_frame: got valid=%b A=%h B=%h expected valid=1 A=%h B=%h", out_valid, A, B, exp_A, exp_B); end
    endtask

    task automatic test_back_to_back();
        handshake();
        set_frame_seq();
        fr[0]  = 32'h8000_0000;
        fr[15] = 32'h7FFF_FFFF;
        fr[16] = 32'h7FFF_FFFF;
        fr[31] = 32'h8000_0000;
        update_expect();
        send(0, 31, 1'b0);
        vectors++;
        if (A[0][0] !== 32'h8000_0000 || A[3][3] !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL extreme_A: got A00=%h A33=%h expected 80000000/7fffffff", A[0][0], A[3][3]); end
        vectors++;
        if (B[0][0] !== 32'h7FFF_FFFF || B[3][3] !== 32'h8000_0000) begin miscompares++; $display("FAIL extreme_B: got B00=%h B33=%h expected 7fffffff/80000000", B[0][0], B[3][3]); end
        vectors++;
        if (A !== exp_A || B !== exp_B) begin miscompares++; $display("FAIL extreme_AB: got A=%h B=%h expected A=%h B=%h", A, B, exp_A, exp_B); end
        // Next frame's first beat is offered during the handshake cycle itself.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0011;
        in_sof    = 1'b1;
        cyc();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_drop: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
        vectors++;
        if (A[0][0] !== 32'h8000_0000) begin miscompares++; $display("FAIL b2b_bubble: got A00=%h expected 80000000", A[0][0]); end
        cyc();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        vectors++;
        if (A[0][0] !== 32'h0000_0011 || frame_err !== 1'b0) begin miscompares++; $display("FAIL b2b_accept: got A00=%h err=%b expected 00000011/0", A[0][0], frame_err); end
        for (int k = 0; k < 32; k++) fr[k] = 32'h0000_2000 + W'(k);
        fr[0] = 32'h0000_0011;
        update_expect();
        send(1, 31, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || A !== exp_A || B !== exp_B) begin miscompares++; $display("FAIL b2b_frame: got valid=%b A=%h B=%h expected valid=1 A=%h B=%h", out_valid, A, B, exp_A, exp_B); end
        handshake();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_missing_sof();
        test_resync();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
